voice_allocator: RTL and testbench

Polyphonic voice allocator that sits between the MIDI decoder and an array of N_VOICES VOICE instances. It accepts note-on/note-off events through a valid/ready handshake and assigns each note to a voice slot, preferring free voices, then released voices, then stealing the least-recently-allocated one. It drives each voice's gate, note-off pulse, note number and velocity. All decisions come from a fixed-length sequential scan, so latency is deterministic.

---
 rtl/voice_alloc_pkg.sv | 26 ++
 rtl/voice_lru.sv | 50 +++++
 rtl/voice_allocator.sv | 243 ++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared types and widths for the polyphonic voice allocator.
// Optional sustain handling is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
package voice_alloc_pkg;

   localparam int unsigned NOTE_W = 7;
   localparam int unsigned VEL_W  = 7;

   typedef enum logic [1:0] {
      SlotFree,
      SlotHeld,
      SlotReleased,
      SlotSustained
   } slot_state_t;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StIssue
   } fsm_state_t;

   // A slot whose gate should be high.
   function automatic logic is_sounding(slot_state_t s);
      return (s == SlotHeld) || (s == SlotSustained);
   endfunction

endpackage

// File: rtl/voice_lru.sv
// LRU rank registers for the voice allocator: promote-to-newest update and an
// oldest-slot query over an arbitrary mask. Rank 0 is newest.
module voice_lru #(
   parameter int unsigned N_VOICES = 4,
   parameter int unsigned RANK_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        promote,
   input  logic [$clog2(N_VOICES)-1:0] promote_idx,
   input  logic [N_VOICES-1:0]         query_mask,
   output logic [$clog2(N_VOICES)-1:0] oldest_idx,
   output logic                        oldest_valid
);

   localparam int unsigned IDX_W = $clog2(N_VOICES);

   logic [RANK_W-1:0] rank_q [N_VOICES];
   logic [RANK_W-1:0] best_rank;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < N_VOICES; v++) begin
            rank_q[v] <= RANK_W'(v);
         end
      end else if (promote) begin
         for (int v = 0; v < N_VOICES; v++) begin
            if (IDX_W'(v) == promote_idx) begin
               rank_q[v] <= '0;
            end else if (rank_q[v] < rank_q[promote_idx]) begin
               rank_q[v] <= rank_q[v] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      oldest_valid = 1'b0;
      oldest_idx   = '0;
      best_rank    = '0;
      for (int v = 0; v < N_VOICES; v++) begin
         if (query_mask[v] && (!oldest_valid || rank_q[v] > best_rank)) begin
            oldest_valid = 1'b1;
            oldest_idx   = IDX_W'(v);
            best_rank    = rank_q[v];
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans slots one per cycle, then issues note-on/off.
// Define VOICE_ALLOC_SUSTAIN_EN to build the SUSTAINED state and pedal handling.
module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int unsigned N_VOICES = 4,
   parameter int unsigned RANK_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ev_valid,
   output logic                       ev_ready,
   input  logic                       ev_is_on,
   input  logic [NOTE_W-1:0]          ev_note,
   input  logic [VEL_W-1:0]           ev_vel,
   input  logic                       sustain,
   output logic [N_VOICES-1:0]        voice_gate,
   output logic [N_VOICES-1:0]        voice_off,
   output logic [NOTE_W*N_VOICES-1:0] voice_note,
   output logic [VEL_W*N_VOICES-1:0]  voice_vel,
   output logic [N_VOICES-1:0]        busy_mask
);

   localparam int unsigned IDX_W = $clog2(N_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

   fsm_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              on_q;
   logic [NOTE_W-1:0] note_q;
   logic [VEL_W-1:0]  vel_q;
   logic              latch;

   logic              retrig_hit_q, retrig_hit_d;
   logic [IDX_W-1:0]  retrig_idx_q, retrig_idx_d;
   logic              free_hit_q, free_hit_d;
   logic [IDX_W-1:0]  free_idx_q, free_idx_d;
   logic              off_hit_q, off_hit_d;
   logic [IDX_W-1:0]  off_idx_q, off_idx_d;

   slot_state_t       slot_q [N_VOICES];
   logic [NOTE_W-1:0] slot_note_q [N_VOICES];
   logic [VEL_W-1:0]  slot_vel_q [N_VOICES];
   logic [N_VOICES-1:0] gate_q, off_q;

   logic              issue, sus_flush, sus_fall, hold_off;
   logic              do_on, do_off, release_off, to_sus;
   logic [IDX_W-1:0]  on_target;
   logic [N_VOICES-1:0] rel_mask, snd_mask, query_mask, kill;
   logic [IDX_W-1:0]  oldest_idx;
   logic              oldest_valid;

`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic sustain_q;

   // Pedal is only sampled in IDLE so a release during a scan is seen on return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sustain_q <= 1'b0;
      end else if (state_q == StIdle) begin
         sustain_q <= sustain;
      end
   end

   assign sus_fall = sustain_q & ~sustain;
   assign hold_off = sustain;
`else
   logic unused_sustain;
   assign unused_sustain = sustain;
   assign sus_fall       = 1'b0;
   assign hold_off       = 1'b0;
`endif

   assign ev_ready = (state_q == StIdle) && !sus_fall;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      retrig_hit_d = retrig_hit_q;
      retrig_idx_d = retrig_idx_q;
      free_hit_d   = free_hit_q;
      free_idx_d   = free_idx_q;
      off_hit_d    = off_hit_q;
      off_idx_d    = off_idx_q;
      latch        = 1'b0;
      issue        = 1'b0;
      sus_flush    = 1'b0;
      case (state_q)
         StIdle: begin
            if (sus_fall) begin
               sus_flush = 1'b1;
            end else if (ev_valid) begin
               latch        = 1'b1;
               idx_d        = '0;
               retrig_hit_d = 1'b0;
               free_hit_d   = 1'b0;
               off_hit_d    = 1'b0;
               state_d      = StScan;
            end
         end
         StScan: begin
            if (slot_q[idx_q] != SlotFree && slot_note_q[idx_q] == note_q && !retrig_hit_q) begin
               retrig_hit_d = 1'b1;
               retrig_idx_d = idx_q;
            end
            if (slot_q[idx_q] == SlotFree && !free_hit_q) begin
               free_hit_d = 1'b1;
               free_idx_d = idx_q;
            end
            if (slot_q[idx_q] == SlotHeld && slot_note_q[idx_q] == note_q && !off_hit_q) begin
               off_hit_d = 1'b1;
               off_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = StIssue;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StIssue: begin
            issue   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         on_q         <= 1'b0;
         note_q       <= '0;
         vel_q        <= '0;
         retrig_hit_q <= 1'b0;
         retrig_idx_q <= '0;
         free_hit_q   <= 1'b0;
         free_idx_q   <= '0;
         off_hit_q    <= 1'b0;
         off_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         retrig_hit_q <= retrig_hit_d;
         retrig_idx_q <= retrig_idx_d;
         free_hit_q   <= free_hit_d;
         free_idx_q   <= free_idx_d;
         off_hit_q    <= off_hit_d;
         off_idx_q    <= off_idx_d;
         if (latch) begin
            on_q   <= ev_is_on && (ev_vel != '0);
            note_q <= ev_note;
            vel_q  <= ev_vel;
         end
      end
   end

   // Released slots are preferred over stealing a sounding one.
   always_comb begin
      for (int v = 0; v < N_VOICES; v++) begin
         rel_mask[v] = (slot_q[v] == SlotReleased);
         snd_mask[v] = is_sounding(slot_q[v]);
      end
      query_mask = (|rel_mask) ? rel_mask : snd_mask;
   end

   voice_lru #(
      .N_VOICES (N_VOICES),
      .RANK_W   (RANK_W)
   ) u_lru (
      .clk          (clk),
      .rst          (rst),
      .promote      (do_on),
      .promote_idx  (on_target),
      .query_mask   (query_mask),
      .oldest_idx   (oldest_idx),
      .oldest_valid (oldest_valid)
   );

   assign on_target   = retrig_hit_q ? retrig_idx_q : (free_hit_q ? free_idx_q : oldest_idx);
   assign do_on       = issue && on_q && (retrig_hit_q || free_hit_q || oldest_valid);
   assign do_off      = issue && !on_q && off_hit_q;
   assign release_off = do_off && !hold_off;
   assign to_sus      = do_off && hold_off;

   always_comb begin
      kill = '0;
      if (do_on) kill[on_target] = 1'b1;
      if (release_off) kill[off_idx_q] = 1'b1;
      for (int v = 0; v < N_VOICES; v++) begin
         if (sus_flush && slot_q[v] == SlotSustained) kill[v] = 1'b1;
      end
   end

   // Gate follows slot state one cycle late, forced low in the cycle a slot is hit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < N_VOICES; v++) begin
            slot_q[v]      <= SlotFree;
            slot_note_q[v] <= '0;
            slot_vel_q[v]  <= '0;
         end
         gate_q <= '0;
         off_q  <= '0;
      end else begin
         off_q <= '0;
         for (int v = 0; v < N_VOICES; v++) begin
            gate_q[v] <= is_sounding(slot_q[v]) && !kill[v];
            if (sus_flush && slot_q[v] == SlotSustained) begin
               slot_q[v] <= SlotReleased;
               off_q[v]  <= 1'b1;
            end
         end
         if (do_on) begin
            slot_q[on_target]      <= SlotHeld;
            slot_note_q[on_target] <= note_q;
            slot_vel_q[on_target]  <= vel_q;
         end
         if (release_off) begin
            slot_q[off_idx_q] <= SlotReleased;
            off_q[off_idx_q]  <= 1'b1;
         end
         if (to_sus) begin
            slot_q[off_idx_q] <= SlotSustained;
         end
      end
   end

   always_comb begin
      voice_note = '0;
      voice_vel  = '0;
      busy_mask  = '0;
      for (int v = 0; v < N_VOICES; v++) begin
         voice_note[v*NOTE_W +: NOTE_W] = slot_note_q[v];
         voice_vel[v*VEL_W +: VEL_W]    = slot_vel_q[v];
         busy_mask[v]                   = (slot_q[v] != SlotFree);
      end
   end

   assign voice_gate = gate_q;
   assign voice_off  = off_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator with N_VOICES=4.
// Covers allocation, stealing, retrigger, release, sustain and mid-scan reset.
module tb_voice_allocator;

   localparam int unsigned NV = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ev_valid, ev_ready, ev_is_on, sustain;
   logic [6:0]    ev_note, ev_vel;
   logic [NV-1:0] voice_gate, voice_off, busy_mask;
   logic [7*NV-1:0] voice_note, voice_vel;
   logic [15:0]   ranks;

   int tests = 0;
   int fails = 0;

   voice_allocator #(
      .N_VOICES (NV),
      .RANK_W   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_is_on   (ev_is_on),
      .ev_note    (ev_note),
      .ev_vel     (ev_vel),
      .sustain    (sustain),
      .voice_gate (voice_gate),
      .voice_off  (voice_off),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .busy_mask  (busy_mask)
   );

   always #5 clk = ~clk;

   assign ranks = {dut.u_lru.rank_q[3], dut.u_lru.rank_q[2],
                   dut.u_lru.rank_q[1], dut.u_lru.rank_q[0]};

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one event; returns #1 after the transfer edge with inputs scrambled.
   task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
      int w;
      w = 0;
      @(negedge clk);
      while (!ev_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_send", ev_ready, 1);
      ev_valid = 1'b1;
      ev_is_on = on;
      ev_note  = n;
      ev_vel   = v;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      ev_is_on = ~on;
      ev_note  = 7'h7f;
      ev_vel   = 7'h7f;
      check("ready_low_after_xfer", ev_ready, 0);
   endtask

   task automatic wait_issue();
      repeat (NV + 1) @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      ev_valid = 1'b0;
      ev_is_on = 1'b0;
      ev_note = '0;
      ev_vel = '0;
      sustain = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gate", voice_gate, 0);
      check("rst_off", voice_off, 0);
      check("rst_note", voice_note, 0);
      check("rst_vel", voice_vel, 0);
      check("rst_busy", busy_mask, 0);
      check("rst_ranks", ranks, 16'h3210);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_ready", ev_ready, 1);

      // First note lands in slot 0; gate rises one cycle after ISSUE.
      send(1'b1, 7'd60, 7'd100);
      wait_issue();
      check("n60_busy", busy_mask, 4'b0001);
      check("n60_note", voice_note[6:0], 60);
      check("n60_vel", voice_vel[6:0], 100);
      check("n60_gate_issue", voice_gate, 4'b0000);
      check("n60_ready", ev_ready, 1);
      step();
      check("n60_gate_up", voice_gate, 4'b0001);

      send(1'b1, 7'd62, 7'd10);
      wait_issue();
      step();
      send(1'b1, 7'd64, 7'd20);
      wait_issue();
      step();
      send(1'b1, 7'd65, 7'd30);
      wait_issue();
      step();
      check("fill_busy", busy_mask, 4'b1111);
      check("fill_gate", voice_gate, 4'b1111);
      check("fill_ranks", ranks, 16'h0123);

      // Steal the oldest (slot 0).
      send(1'b1, 7'd67, 7'd40);
      wait_issue();
      check("steal_gate_dip", voice_gate, 4'b1110);
      check("steal_notes", voice_note, {7'd65, 7'd64, 7'd62, 7'd67});
      check("steal_ranks", ranks, 16'h1230);
      step();
      check("steal_gate_up", voice_gate, 4'b1111);

      // Retrigger held 64 in slot 2.
      send(1'b1, 7'd64, 7'd99);
      wait_issue();
      check("retrig_gate_dip", voice_gate, 4'b1011);
      check("retrig_notes", voice_note, {7'd65, 7'd64, 7'd62, 7'd67});
      check("retrig_vels", voice_vel, {7'd30, 7'd99, 7'd10, 7'd40});
      check("retrig_ranks", ranks, 16'h2031);
      step();
      check("retrig_gate_up", voice_gate, 4'b1111);

      // Note-off 62 in slot 1.
      send(1'b0, 7'd62, 7'd0);
      wait_issue();
      check("off62_pulse", voice_off, 4'b0010);
      check("off62_gate", voice_gate, 4'b1101);
      check("off62_busy", busy_mask, 4'b1111);
      step();
      check("off62_pulse_end", voice_off, 4'b0000);
      check("off62_note_kept", voice_note[13:7], 62);

      // Note-off of an absent note is consumed with no effect.
      send(1'b0, 7'd70, 7'd0);
      repeat (NV) @(posedge clk);
      #1;
      check("off70_ready_busy", ev_ready, 0);
      step();
      check("off70_ready_back", ev_ready, 1);
      check("off70_off", voice_off, 4'b0000);
      check("off70_gate", voice_gate, 4'b1101);
      check("off70_notes", voice_note, {7'd65, 7'd64, 7'd62, 7'd67});

      // Velocity 0 note-on releases slot 3.
      send(1'b1, 7'd65, 7'd0);
      wait_issue();
      check("vel0_pulse", voice_off, 4'b1000);
      check("vel0_gate", voice_gate, 4'b0101);
      step();
      check("vel0_pulse_end", voice_off, 4'b0000);

      // Oldest released slot (1) is reused before stealing.
      send(1'b1, 7'd72, 7'd5);
      wait_issue();
      check("reuse_gate", voice_gate, 4'b0101);
      check("reuse_notes", voice_note, {7'd65, 7'd64, 7'd72, 7'd67});
      check("reuse_ranks", ranks, 16'h3102);
      step();
      check("reuse_gate_up", voice_gate, 4'b0111);
      check("reuse_vels", voice_vel, {7'd30, 7'd99, 7'd5, 7'd40});

      @(negedge clk);
      sustain = 1'b1;
      @(posedge clk);
      send(1'b0, 7'd72, 7'd0);
      wait_issue();
`ifdef VOICE_ALLOC_SUSTAIN_EN
      check("sus_hold_gate", voice_gate, 4'b0111);
      check("sus_hold_off", voice_off, 4'b0000);
      step();
      @(negedge clk);
      sustain = 1'b0;
      #1;
      check("sus_fall_ready", ev_ready, 0);
      @(posedge clk);
      #1;
      check("sus_fall_pulse", voice_off, 4'b0010);
      check("sus_fall_gate", voice_gate, 4'b0101);
      check("sus_fall_ready_back", ev_ready, 1);
      step();
      check("sus_fall_pulse_end", voice_off, 4'b0000);
`else
      check("nosus_pulse", voice_off, 4'b0010);
      check("nosus_gate", voice_gate, 4'b0101);
      step();
      check("nosus_pulse_end", voice_off, 4'b0000);
      @(negedge clk);
      sustain = 1'b0;
`endif

      // Reset in the middle of a scan.
      send(1'b1, 7'd80, 7'd9);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_gate", voice_gate, 0);
      check("midrst_off", voice_off, 0);
      check("midrst_note", voice_note, 0);
      check("midrst_vel", voice_vel, 0);
      check("midrst_busy", busy_mask, 0);
      check("midrst_ranks", ranks, 16'h3210);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ready", ev_ready, 1);
      send(1'b1, 7'd50, 7'd7);
      wait_issue();
      check("post_rst_busy", busy_mask, 4'b0001);
      check("post_rst_note", voice_note, {7'd0, 7'd0, 7'd0, 7'd50});
      step();
      check("post_rst_gate", voice_gate, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
